// File: rtl/ysyx_23060061_idu_if.sv
// IFU->IDU->EXU handshake bundle: fetch beat in, decoded head entry out.
interface ysyx_23060061_idu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_aluOp;
  logic            out_aluAsel, out_aluBsel, out_RegWrite;
  logic [1:0]      out_MemRW;
  logic [2:0]      out_memExt;
  logic [3:0]      out_wmask;
  logic [1:0]      out_WBSel;
  logic [2:0]      out_brType;
  logic            out_isBranch, out_isJal, out_isJalr;
  logic            out_mduEn;
  logic [2:0]      out_mduOp;
  logic            out_ebreak, out_ecall, out_illegal;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_aluOp, out_aluAsel, out_aluBsel, out_RegWrite, out_MemRW,
           out_memExt, out_wmask, out_WBSel, out_brType, out_isBranch,
           out_isJal, out_isJalr, out_mduEn, out_mduOp, out_ebreak,
           out_ecall, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_aluOp, out_aluAsel, out_aluBsel, out_RegWrite, out_MemRW,
           out_memExt, out_wmask, out_WBSel, out_brType, out_isBranch,
           out_isJal, out_isJalr, out_mduEn, out_mduOp, out_ebreak,
           out_ecall, out_illegal
  );
endinterface

// File: rtl/ysyx_23060061_idu.sv
// Registered RV32I/M/E decode stage: combinational decode of the input beat
// written into a DEPTH-entry FIFO whose head drives the EXU-facing fields.
module ysyx_23060061_idu #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter bit EN_M     = 1'b0,
  parameter int NUM_REGS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ysyx_23060061_idu_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluOp;
    logic            aluAsel, aluBsel, RegWrite;
    logic [1:0]      MemRW;
    logic [2:0]      memExt;
    logic [3:0]      wmask;
    logic [1:0]      WBSel;
    logic [2:0]      brType;
    logic            isBranch, isJal, isJalr;
    logic            mduEn;
    logic [2:0]      mduOp;
    logic            ebreak, ecall, illegal;
  } dec_t;

  logic [31:0] inst;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        ill, use_rd, use_rs1, use_rs2;
  dec_t        d, clr;

  assign inst  = bus.in_inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    d       = '0;
    d.pc    = bus.in_pc;
    clr     = '0;
    ill     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    case (opc)
      7'b0110111: begin // lui
        use_rd = 1'b1; imm32 = imm_u; d.aluOp = 4'b0001;
        d.aluBsel = 1'b1; d.RegWrite = 1'b1; d.WBSel = 2'b01;
      end
      7'b0010111: begin // auipc
        use_rd = 1'b1; imm32 = imm_u; d.aluAsel = 1'b1;
        d.aluBsel = 1'b1; d.RegWrite = 1'b1; d.WBSel = 2'b01;
      end
      7'b1101111: begin // jal
        use_rd = 1'b1; imm32 = imm_j; d.aluAsel = 1'b1; d.aluBsel = 1'b1;
        d.RegWrite = 1'b1; d.WBSel = 2'b10; d.isJal = 1'b1;
      end
      7'b1100111: begin // jalr
        use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; d.aluOp = 4'b0010;
        d.aluBsel = 1'b1; d.RegWrite = 1'b1; d.WBSel = 2'b10; d.isJalr = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
      end
      7'b1100011: begin // branch: target only, condition resolved in EXU
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b; d.aluAsel = 1'b1;
        d.aluBsel = 1'b1; d.isBranch = 1'b1; d.brType = f3;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      7'b0000011: begin // load
        use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; d.aluBsel = 1'b1;
        d.RegWrite = 1'b1; d.MemRW = 2'b10; d.WBSel = 2'b00;
        case (f3)
          3'b000:  d.memExt = 3'b001;
          3'b001:  d.memExt = 3'b010;
          3'b010:  d.memExt = 3'b000;
          3'b100:  d.memExt = 3'b011;
          3'b101:  d.memExt = 3'b100;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin // store
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s; d.aluBsel = 1'b1;
        d.MemRW = 2'b01;
        case (f3)
          3'b000:  d.wmask = 4'b0001;
          3'b001:  d.wmask = 4'b0011;
          3'b010:  d.wmask = 4'b1111;
          default: ill = 1'b1;
        endcase
      end
      7'b0010011: begin // op-imm
        use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; d.aluBsel = 1'b1;
        d.RegWrite = 1'b1; d.WBSel = 2'b01;
        case (f3)
          3'b000: d.aluOp = 4'b0000;
          3'b010: d.aluOp = 4'b0101;
          3'b011: d.aluOp = 4'b0100;
          3'b100: d.aluOp = 4'b0110;
          3'b110: d.aluOp = 4'b1000;
          3'b111: d.aluOp = 4'b1001;
          3'b001: begin
            d.aluOp = 4'b1010;
            if (f7 != 7'b0000000) ill = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      d.aluOp = 4'b1011;
            else if (f7 == 7'b0100000) d.aluOp = 4'b0111;
            else                       ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin // op / M
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d.RegWrite = 1'b1; d.WBSel = 2'b01;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d.aluOp = 4'b0000;
            3'b001:  d.aluOp = 4'b1010;
            3'b010:  d.aluOp = 4'b0101;
            3'b011:  d.aluOp = 4'b0100;
            3'b100:  d.aluOp = 4'b0110;
            3'b101:  d.aluOp = 4'b1011;
            3'b110:  d.aluOp = 4'b1000;
            default: d.aluOp = 4'b1001;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d.aluOp = 4'b0011;
          else if (f3 == 3'b101) d.aluOp = 4'b0111;
          else                   ill = 1'b1;
        end else if (f7 == 7'b0000001 && EN_M) begin
          d.mduEn = 1'b1; d.mduOp = f3;
        end else begin
          ill = 1'b1;
        end
      end
      7'b0001111: if (f3 != 3'b000) ill = 1'b1;
      7'b1110011: begin
        if (inst == 32'h0000_0073)      d.ecall  = 1'b1;
        else if (inst == 32'h0010_0073) d.ebreak = 1'b1;
        else                            ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    d.rd  = use_rd  ? inst[11:7]  : 5'd0;
    d.rs1 = use_rs1 ? inst[19:15] : 5'd0;
    d.rs2 = use_rs2 ? inst[24:20] : 5'd0;
    d.imm = XLEN'($signed(imm32));
    if (NUM_REGS == 16 && (d.rd[4] | d.rs1[4] | d.rs2[4])) ill = 1'b1;
    if (d.rd == 5'd0) d.RegWrite = 1'b0;

    // Illegal beats keep only what is taken straight from pc/inst
    if (ill) begin
      clr.pc      = d.pc;
      clr.rd      = d.rd;
      clr.rs1     = d.rs1;
      clr.rs2     = d.rs2;
      clr.imm     = d.imm;
      clr.illegal = 1'b1;
      d           = clr;
    end
  end

  dec_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  dec_t          head;

  assign bus.in_ready  = rst_n & (cnt_q < (AW+1)'(DEPTH));
  assign bus.out_valid = (cnt_q != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push && !flush) mem_q[wptr_q] <= d;
    end
  end

  assign head             = mem_q[rptr_q];
  assign bus.out_pc       = head.pc;
  assign bus.out_rd       = head.rd;
  assign bus.out_rs1      = head.rs1;
  assign bus.out_rs2      = head.rs2;
  assign bus.out_imm      = head.imm;
  assign bus.out_aluOp    = head.aluOp;
  assign bus.out_aluAsel  = head.aluAsel;
  assign bus.out_aluBsel  = head.aluBsel;
  assign bus.out_RegWrite = head.RegWrite;
  assign bus.out_MemRW    = head.MemRW;
  assign bus.out_memExt   = head.memExt;
  assign bus.out_wmask    = head.wmask;
  assign bus.out_WBSel    = head.WBSel;
  assign bus.out_brType   = head.brType;
  assign bus.out_isBranch = head.isBranch;
  assign bus.out_isJal    = head.isJal;
  assign bus.out_isJalr   = head.isJalr;
  assign bus.out_mduEn    = head.mduEn;
  assign bus.out_mduOp    = head.mduOp;
  assign bus.out_ebreak   = head.ebreak;
  assign bus.out_ecall    = head.ecall;
  assign bus.out_illegal  = head.illegal;
endmodule

// File: tb/tb_ysyx_23060061_idu.sv
// Directed bench: dut_a is RV32IM, dut_b is RV32E without M; both see the same stream.
module tb_ysyx_23060061_idu;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;
  int          n_cmp = 0, n_err = 0;

  ysyx_23060061_idu_if #(.XLEN(32)) ifa ();
  ysyx_23060061_idu_if #(.XLEN(32)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_pc     = in_pc;
  assign ifa.in_inst   = in_inst;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_pc     = in_pc;
  assign ifb.in_inst   = in_inst;
  assign ifb.out_ready = out_ready;

  ysyx_23060061_idu #(.XLEN(32), .DEPTH(2), .EN_M(1'b1), .NUM_REGS(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa.slave));
  ysyx_23060061_idu #(.XLEN(32), .DEPTH(2), .EN_M(1'b0), .NUM_REGS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic        asel, bsel, rw;
    logic [1:0]  memrw;
    logic [2:0]  memext;
    logic [3:0]  wmask;
    logic [1:0]  wb;
    logic [2:0]  brt;
    logic        isbr, isjal, isjalr, mdu;
    logic [2:0]  mduop;
    logic        eb, ec, ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e;
    logic        ill_b;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic exp_t act_a();
    exp_t r;
    r.rd = ifa.out_rd; r.rs1 = ifa.out_rs1; r.rs2 = ifa.out_rs2; r.imm = ifa.out_imm;
    r.aluop = ifa.out_aluOp; r.asel = ifa.out_aluAsel; r.bsel = ifa.out_aluBsel;
    r.rw = ifa.out_RegWrite; r.memrw = ifa.out_MemRW; r.memext = ifa.out_memExt;
    r.wmask = ifa.out_wmask; r.wb = ifa.out_WBSel; r.brt = ifa.out_brType;
    r.isbr = ifa.out_isBranch; r.isjal = ifa.out_isJal; r.isjalr = ifa.out_isJalr;
    r.mdu = ifa.out_mduEn; r.mduop = ifa.out_mduOp; r.eb = ifa.out_ebreak;
    r.ec = ifa.out_ecall; r.ill = ifa.out_illegal;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] ins);
    in_inst  = ins;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t ea, aa;
    vt[0]  = '{32'h00500093, exp_t'{rd:5'd1, imm:32'd5, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[1]  = '{32'h402081B3, exp_t'{rd:5'd3, rs1:5'd1, rs2:5'd2, aluop:4'b0011, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[2]  = '{32'h00100073, exp_t'{eb:1'b1, default:'0}, 1'b0};
    vt[3]  = '{32'h027302B3, exp_t'{rd:5'd5, rs1:5'd6, rs2:5'd7, rw:1'b1, wb:2'b01, mdu:1'b1, default:'0}, 1'b1};
    vt[4]  = '{32'h00100813, exp_t'{rd:5'd16, imm:32'd1, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b1};
    vt[5]  = '{32'h00100793, exp_t'{rd:5'd15, imm:32'd1, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[6]  = '{32'h123452B7, exp_t'{rd:5'd5, imm:32'h12345000, aluop:4'b0001, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[7]  = '{32'hFFC12303, exp_t'{rd:5'd6, rs1:5'd2, imm:32'hFFFFFFFC, bsel:1'b1, rw:1'b1, memrw:2'b10, default:'0}, 1'b0};
    vt[8]  = '{32'h007401A3, exp_t'{rs1:5'd8, rs2:5'd7, imm:32'd3, bsel:1'b1, memrw:2'b01, wmask:4'b0001, default:'0}, 1'b0};
    vt[9]  = '{32'hFE208CE3, exp_t'{rs1:5'd1, rs2:5'd2, imm:32'hFFFFFFF8, asel:1'b1, bsel:1'b1, isbr:1'b1, default:'0}, 1'b0};
    vt[10] = '{32'h010000EF, exp_t'{rd:5'd1, imm:32'd16, asel:1'b1, bsel:1'b1, rw:1'b1, wb:2'b10, isjal:1'b1, default:'0}, 1'b0};
    vt[11] = '{32'h00008067, exp_t'{rs1:5'd1, aluop:4'b0010, bsel:1'b1, wb:2'b10, isjalr:1'b1, default:'0}, 1'b0};
    vt[12] = '{32'h40325213, exp_t'{rd:5'd4, rs1:5'd4, imm:32'h403, aluop:4'b0111, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[13] = '{32'h02009093, exp_t'{ill:1'b1, default:'0}, 1'b1};
    vt[14] = '{32'h00000010, exp_t'{ill:1'b1, default:'0}, 1'b1};
    vt[15] = '{32'h00000073, exp_t'{ec:1'b1, default:'0}, 1'b0};
    vt[16] = '{32'h00200073, exp_t'{ill:1'b1, default:'0}, 1'b1};
    vt[17] = '{32'h0000000F, exp_t'{default:'0}, 1'b0};
    vt[18] = '{32'h00255483, exp_t'{rd:5'd9, rs1:5'd10, imm:32'd2, bsel:1'b1, rw:1'b1, memrw:2'b10, memext:3'b100, default:'0}, 1'b0};
    vt[19] = '{32'h00D635B3, exp_t'{rd:5'd11, rs1:5'd12, rs2:5'd13, aluop:4'b0100, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[20] = '{32'h00001117, exp_t'{rd:5'd2, imm:32'h1000, asel:1'b1, bsel:1'b1, rw:1'b1, wb:2'b01, default:'0}, 1'b0};
    vt[21] = '{32'h0041C463, exp_t'{rs1:5'd3, rs2:5'd4, imm:32'd8, asel:1'b1, bsel:1'b1, isbr:1'b1, brt:3'b100, default:'0}, 1'b0};

    // reset state
    tick(); tick();
    chk("rst_in_ready", 128'(ifa.in_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(ifa.out_valid), 128'(1'b0));
    chk("rst_fields", 128'(act_a()), 128'(0));
    chk("rst_pc", 128'(ifa.out_pc), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(ifa.in_ready), 128'(1'b1));

    // single-beat decode table; also walks the FIFO pointers around
    for (int i = 0; i < NV; i++) begin
      in_pc = 32'h8000_0000 + 32'(i) * 32'd4;
      push1(vt[i].inst);
      chk($sformatf("v%0d_valid", i), 128'(ifa.out_valid), 128'(1'b1));
      ea = vt[i].e;
      aa = act_a();
      if (ea.ill) begin
        aa.rd = '0; aa.rs1 = '0; aa.rs2 = '0; aa.imm = '0;
      end
      chk($sformatf("v%0d_dec", i), 128'(aa), 128'(ea));
      chk($sformatf("v%0d_pc", i), 128'(ifa.out_pc), 128'(in_pc));
      chk($sformatf("v%0d_ill_e", i), 128'(ifb.out_illegal), 128'(vt[i].ill_b));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_empty", i), 128'(ifa.out_valid), 128'(1'b0));
    end

    // full FIFO back-pressure, then in-order drain
    push1(vt[1].inst);
    push1(vt[2].inst);
    chk("full_in_ready", 128'(ifa.in_ready), 128'(1'b0));
    in_inst = vt[0].inst; in_valid = 1'b1;
    tick();
    chk("held_in_ready", 128'(ifa.in_ready), 128'(1'b0));
    chk("held_head_sub", 128'(act_a()), 128'(vt[1].e));
    out_ready = 1'b1;
    tick();
    chk("pop2_ebreak", 128'(act_a()), 128'(vt[2].e));
    chk("pop2_in_ready", 128'(ifa.in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("pop3_addi", 128'(act_a()), 128'(vt[0].e));
    chk("pop3_valid", 128'(ifa.out_valid), 128'(1'b1));
    tick();
    out_ready = 1'b0;
    chk("drained", 128'(ifa.out_valid), 128'(1'b0));

    // flush with a live push accepted (count 1): pushed beat must vanish
    push1(vt[0].inst);
    flush = 1'b1; in_inst = vt[6].inst; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 128'(ifa.out_valid), 128'(1'b0));
    chk("flush1_in_ready", 128'(ifa.in_ready), 128'(1'b1));
    tick();
    chk("flush1_no_ghost", 128'(ifa.out_valid), 128'(1'b0));
    push1(vt[10].inst);
    chk("flush1_next", 128'(act_a()), 128'(vt[10].e));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // flush while full
    push1(vt[0].inst);
    push1(vt[1].inst);
    flush = 1'b1; in_inst = vt[6].inst; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", 128'(ifa.out_valid), 128'(1'b0));
    chk("flush2_in_ready", 128'(ifa.in_ready), 128'(1'b1));
    tick();
    chk("flush2_no_ghost", 128'(ifa.out_valid), 128'(1'b0));

    // reset mid-stream with two queued entries
    push1(vt[6].inst);
    push1(vt[7].inst);
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", 128'(ifa.out_valid), 128'(1'b0));
    chk("rst2_in_ready", 128'(ifa.in_ready), 128'(1'b0));
    chk("rst2_fields", 128'(act_a()), 128'(0));
    rst_n = 1'b1;
    push1(vt[0].inst);
    chk("rst2_first_valid", 128'(ifa.out_valid), 128'(1'b1));
    chk("rst2_first", 128'(act_a()), 128'(vt[0].e));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
